// File: rtl/serial_add_sub.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per clock, LSB digit first,
// start/busy/done handshake. Define SERIAL_ADD_SUB_SAT_EN for signed saturation on overflow.
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Overflow,
    output logic             Zero
);

    localparam int N     = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    generate
        if ((WIDTH < 2) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
            $error("serial_add_sub: WIDTH must be >= 2 and DIGIT must divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

`ifdef SERIAL_ADD_SUB_SAT_EN
    function automatic logic [WIDTH-1:0] sat_value(input logic neg);
        sat_value = {neg, {(WIDTH-1){~neg}}};
    endfunction
`endif

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   opa_r;
    logic [WIDTH-1:0]   opb_r;
    logic [WIDTH-1:0]   acc_r;
    logic               c_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               a_msb_r;
    logic               b_msb_r;
    logic [WIDTH-1:0]   sum_r;
    logic               carry_r;
    logic               ovf_r;
    logic               zero_r;

    logic               accept_s;
    logic               last_s;
    logic [DIGIT:0]     dsum_s;
    logic [WIDTH+DIGIT-1:0] acc_ext_s;
    logic [WIDTH-1:0]   acc_next_s;
    logic               ovf_s;
    logic [WIDTH-1:0]   sum_fin_s;

    // Handshake decode: start is only honoured while ready (IDLE or DONE)
    always_comb begin
        accept_s = 1'b0;
        last_s   = 1'b0;
        if (start && ((state_r == ST_IDLE) || (state_r == ST_DONE))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if ((state_r == ST_RUN) && (cnt_r == CNT_LAST)) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_RUN;
                else       state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (last_s) state_s = ST_DONE;
                else        state_s = ST_RUN;
            end
            ST_DONE: begin
                if (start) state_s = ST_RUN;
                else       state_s = ST_IDLE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Digit adder, result shift and final flag evaluation
    always_comb begin
        dsum_s     = {1'b0, opa_r[DIGIT-1:0]} + {1'b0, opb_r[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_r};
        acc_ext_s  = {dsum_s[DIGIT-1:0], acc_r};
        acc_next_s = acc_ext_s[WIDTH+DIGIT-1:DIGIT];
        // operands with equal sign producing a result of the other sign
        ovf_s      = (a_msb_r == b_msb_r) && (acc_next_s[WIDTH-1] != a_msb_r);
`ifdef SERIAL_ADD_SUB_SAT_EN
        if (ovf_s) begin
            sum_fin_s = sat_value(a_msb_r);
        end else begin
            sum_fin_s = acc_next_s;
        end
`else
        sum_fin_s  = acc_next_s;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture and digit-serial shifting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_r   <= {WIDTH{1'b0}};
            opb_r   <= {WIDTH{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            c_r     <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
        end else if (accept_s) begin
            opa_r   <= A;
            opb_r   <= B ^ {WIDTH{m}};
            acc_r   <= {WIDTH{1'b0}};
            c_r     <= m;
            cnt_r   <= {CNT_W{1'b0}};
            a_msb_r <= A[WIDTH-1];
            b_msb_r <= B[WIDTH-1] ^ m;
        end else if (state_r == ST_RUN) begin
            opa_r   <= opa_r >> DIGIT;
            opb_r   <= opb_r >> DIGIT;
            acc_r   <= acc_next_s;
            c_r     <= dsum_s[DIGIT];
            cnt_r   <= cnt_r + CNT_ONE;
        end
    end

    // Result and flag registers, loaded only on the final RUN edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
            zero_r  <= 1'b0;
        end else if (last_s) begin
            sum_r   <= sum_fin_s;
            carry_r <= dsum_s[DIGIT];
            ovf_r   <= ovf_s;
            zero_r  <= (sum_fin_s == {WIDTH{1'b0}});
        end
    end

    assign busy     = (state_r == ST_RUN);
    assign done     = (state_r == ST_DONE);
    assign Sum      = sum_r;
    assign Carry    = carry_r;
    assign Overflow = ovf_r;
    assign Zero     = zero_r;

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Parametrised, multi-cycle, digit-serial two's-complement adder/subtractor; successor to the fixed 4-bit combinational adder-subtractor.
- Processes DIGIT bits per clock, LSB digit first, with a start/busy/done handshake.
- Registers result, carry, signed overflow and zero flags.
- Sits beside the datapath ALU wherever area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly.
  - N = WIDTH/DIGIT = number of RUN cycles.
  - Illegal combinations trigger an elaboration-time $error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when ready (IDLE or DONE state)
- A  input  WIDTH  operand A, captured on accepted start
- B  input  WIDTH  operand B, captured on accepted start
- m  input  1  mode, captured on accepted start: 0 = A+B, 1 = A−B
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse, high in DONE
- Sum  output  WIDTH  result, registered
- Carry  output  1  adder carry-out
  - Add: unsigned carry.
  - Subtract: 1 = no borrow (A ≥ B unsigned).
- Overflow  output  1  signed two's-complement overflow of the operation
- Zero  output  1  Sum == 0

Behaviour:
- Reset (async, rst_n low):
  - State IDLE.
  - busy, done, Sum, Carry, Overflow, Zero all 0.
  - Internal shift registers and counter cleared.
  - Effective immediately, including mid-RUN; the in-flight operation is discarded.
  - Release is synchronous to the next clk edge.
- States:
  - IDLE: start=1 → RUN. Capture opA=A, opB=B^{WIDTH{m}}, c=m, cnt=0.
  - RUN: each edge:
    - Take the low DIGIT bits of opA and opB.
    - {c, d} = opA_d + opB_d + c.
    - Shift opA and opB right by DIGIT.
    - Shift d into the MSB end of the partial-result register.
    - cnt++.
    - On the edge processing digit N−1 → DONE, and load output registers:
      - Sum = partial result.
      - Carry = final c.
      - Overflow = (A[MSB]==opB[MSB]) && (Sum[MSB]!=A[MSB]), using the captured values.
      - Zero = (Sum==0).
  - DONE: done=1 for exactly one cycle.
    - start=1 → RUN with a new capture (back-to-back).
    - Otherwise → IDLE.
- start in RUN: ignored, no queuing. A, B and m may change freely after capture without affecting the result.
- Latency:
  - Start accepted at edge E0; done high in the cycle following edge E0+N.
  - Throughput is one result per N+1 cycles with start held high.
- Outputs:
  - Sum and flags change only on the RUN→DONE edge, and hold until the next completion or reset.
  - They are stable and valid while done=1 and afterwards.
- busy is combinationally equal to (state==RUN); done to (state==DONE). Neither is ever high simultaneously with the other.
- Arithmetic wraps modulo 2^WIDTH unless the optional feature is enabled.
- DIGIT==WIDTH is legal: N=1, so done follows start by one edge.

Optional Feature:
- Macro: SERIAL_ADD_SUB_SAT_EN.
- Defined: when Overflow=1, Sum is loaded with signed saturation instead of the wrapped value:
  - 0111…1 if A[MSB]==0.
  - 1000…0 if A[MSB]==1.
  - Overflow still reports 1. Carry is unchanged (raw adder carry). Zero is computed from the saturated Sum.
- Undefined: Sum is always the wrapped result; no saturation logic is synthesised.

Test Plan:
1. WIDTH=4, DIGIT=1: A=1101, B=0011, m=0, start one cycle → done exactly 4 edges later (cycle after E0+4); Sum=0000, Carry=1, Overflow=0, Zero=1; busy high for 4 cycles.
2. WIDTH=4, DIGIT=1: A=1111, B=0011, m=1 → Sum=1100, Carry=1, Overflow=0, Zero=0. Then A=0011, B=0101, m=1 → Sum=1110, Carry=0, Overflow=0.
3. WIDTH=4, DIGIT=1: A=1001, B=0011, m=1 → without SAT_EN: Sum=0110, Overflow=1, Carry=1. With SERIAL_ADD_SUB_SAT_EN: Sum=1000, Overflow=1.
4. WIDTH=8, DIGIT=4: A=0x7F, B=0x01, m=0 → done after 2 RUN edges; Sum=0x80, Overflow=1, Carry=0. Start held high through DONE gives a back-to-back op: A=0xFF, B=0x01 → Sum=0x00, Carry=1, Zero=1; no IDLE cycle between ops.
5. Start asserted mid-RUN with different operands → ignored; result matches the first operands. A, B and m toggled during RUN → result unaffected.
6. rst_n pulled low for 1 ns mid-RUN (between edges) → busy, done, Sum and flags go 0 immediately. After release, a new start completes normally with the full N-cycle latency.
